// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch program counter.
// Optional feature macro used by this slice: PC_ALIGN_CHECK_EN.
package pc_pkg;

    typedef enum logic [1:0] {
        BR_REL  = 2'b00,
        BR_JMP  = 2'b01,
        BR_JREG = 2'b10,
        BR_NONE = 2'b11
    } br_type_t;

    typedef enum logic [1:0] {
        PC_RUN  = 2'b00,
        PC_SLOT = 2'b01,
        PC_HALT = 2'b10
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] PC_HALT_ADDR    = 32'h0000_0000;
    localparam int          PC_MIN_ADDR_W   = 28;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target, sequential address and link address generation.
// PC_ALIGN_CHECK_EN undefined: register-jump targets are word-aligned by masking bits [1:0].
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        br_type,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       j_index,
    input  logic [ADDR_W-1:0] rs_val,
    output logic [ADDR_W-1:0] seq,
    output logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] link_addr
);

    logic [ADDR_W-1:0] rel_off;
    logic [ADDR_W-1:0] rel_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] reg_tgt;

    assign seq       = pc + ADDR_W'(4);
    assign link_addr = pc + ADDR_W'(8);

    // Word offset: sign-extend then scale by 4.
    assign rel_off = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
    assign rel_tgt = seq + rel_off;

    generate
        if (ADDR_W > 28) begin : g_region_hi
            assign jmp_tgt = {seq[ADDR_W-1:28], j_index, 2'b00};
        end else begin : g_region_only
            assign jmp_tgt = {j_index, 2'b00};
        end
    endgenerate

`ifdef PC_ALIGN_CHECK_EN
    assign reg_tgt = rs_val;
`else
    assign reg_tgt = rs_val & ~ADDR_W'(3);
`endif

    always_comb begin
        target = reg_tgt;
        case (br_type)
            BR_REL:  target = rel_tgt;
            BR_JMP:  target = jmp_tgt;
            default: target = reg_tgt;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with branch-delay slot, stall hold and halt on redirect to HALT_ADDR.
// Optional macro PC_ALIGN_CHECK_EN: misaligned register-jump targets raise a sticky fault and halt.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = PC_HALT_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       j_index,
    input  logic [ADDR_W-1:0] rs_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              in_delay_slot,
    output logic              active,
    output logic              misalign_fault
);

    generate
        if (ADDR_W < PC_MIN_ADDR_W) begin : g_addr_w_check
            $error("pc_unit: ADDR_W must be at least 28");
        end
    endgenerate

    localparam logic [1:0] S_RUN  = PC_RUN;
    localparam logic [1:0] S_SLOT = PC_SLOT;
    localparam logic [1:0] S_HALT = PC_HALT;

    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] HALT_PC = ADDR_W'(HALT_ADDR);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              active_q, active_d;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] target;

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;
`endif

    pc_target_calc #(
        .ADDR_W(ADDR_W)
    ) u_target_calc (
        .pc       (pc_q),
        .br_type  (br_type),
        .br_offset(br_offset),
        .j_index  (j_index),
        .rs_val   (rs_val),
        .seq      (seq),
        .target   (target),
        .link_addr(link_addr)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        active_d = active_q;
`ifdef PC_ALIGN_CHECK_EN
        fault_d  = fault_q;
`endif
        if (!stall) begin
            case (state_q)
                S_RUN: begin
                    if (br_valid && (br_type != BR_NONE)) begin
`ifdef PC_ALIGN_CHECK_EN
                        if ((br_type == BR_JREG) && (rs_val[1:0] != 2'b00)) begin
                            fault_d  = 1'b1;
                            active_d = 1'b0;
                            state_d  = S_HALT;
                        end else begin
                            pend_d  = target;
                            pc_d    = seq;
                            state_d = S_SLOT;
                        end
`else
                        pend_d  = target;
                        pc_d    = seq;
                        state_d = S_SLOT;
`endif
                    end else begin
                        pc_d = seq;
                    end
                end
                // A redirect issued from the delay slot is undefined, so br_valid is ignored here.
                S_SLOT: begin
                    pc_d = pend_q;
                    if (pend_q == HALT_PC) begin
                        state_d  = S_HALT;
                        active_d = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pc_q     <= RST_PC;
            pend_q   <= '0;
            active_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign misalign_fault = fault_q;
`else
    assign misalign_fault = 1'b0;
`endif

    assign pc            = pc_q;
    assign active        = active_q;
    assign in_delay_slot = (state_q == S_SLOT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus pushes expected post-edge state, monitor pops and compares.
// Honours PC_ALIGN_CHECK_EN for the misaligned register-jump scenario.
module tb_pc_unit;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic [15:0] br_offset = '0;
    logic [25:0] j_index = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        in_delay_slot;
    logic        active;
    logic        misalign_fault;

    typedef struct {
        logic [31:0] pc;
        logic        ds;
        logic        act;
        logic        flt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   rec_no = 0;

    pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_type       (br_type),
        .br_offset     (br_offset),
        .j_index       (j_index),
        .rs_val        (rs_val),
        .pc            (pc),
        .link_addr     (link_addr),
        .in_delay_slot (in_delay_slot),
        .active        (active),
        .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s rec%0d: got %h expected %h", nm, rec_no, act, exp);
        end
    endtask

    // Monitor: DUT state is presented every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            rec_no++;
            chk("pc", pc, e.pc);
            chk("link", link_addr, e.pc + 32'd8);
            chk("dslot", {31'd0, in_delay_slot}, {31'd0, e.ds});
            chk("active", {31'd0, active}, {31'd0, e.act});
            chk("fault", {31'd0, misalign_fault}, {31'd0, e.flt});
        end
    end

    task automatic push(input logic [31:0] epc, input logic eds, input logic eact, input logic eflt);
        exp_t e;
        e.pc = epc; e.ds = eds; e.act = eact; e.flt = eflt;
        q.push_back(e);
    endtask

    task automatic cyc(input logic st, input logic v, input logic [1:0] t, input logic [15:0] off,
                       input logic [25:0] ji, input logic [31:0] rs,
                       input logic [31:0] epc, input logic eds, input logic eact, input logic eflt);
        stall = st; br_valid = v; br_type = t; br_offset = off; j_index = ji; rs_val = rs;
        @(posedge clk);
        #1;
        push(epc, eds, eact, eflt);
        stall = 1'b0; br_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] epc);
        cyc(1'b0, 1'b0, BR_REL, 16'h0, 26'h0, 32'h0, epc, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        push(32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] p;
        do_reset();

        // Sequential fetch after reset.
        run(32'hBFC0_0004);
        run(32'hBFC0_0008);
        run(32'hBFC0_000C);
        run(32'hBFC0_0010);

        // Backward relative branch: slot at +4, then seq - 16.
        cyc(1'b0, 1'b1, BR_REL, 16'hFFFC, 26'h0, 32'h0, 32'hBFC0_0014, 1'b1, 1'b1, 1'b0);
        run(32'hBFC0_0004);
        p = 32'hBFC0_0004;
        for (int i = 0; i < 7; i++) begin
            p = p + 32'd4;
            run(p);
        end

        // Region jump from BFC00020 (link BFC00028 checked on the record above).
        cyc(1'b0, 1'b1, BR_JMP, 16'h0, 26'h0000040, 32'h0, 32'hBFC0_0024, 1'b1, 1'b1, 1'b0);
        run(32'hB000_0100);

        // Forward branch, then stall for 3 cycles in the slot with an ignored br_valid.
        cyc(1'b0, 1'b1, BR_REL, 16'h0008, 26'h0, 32'h0, 32'hB000_0104, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, BR_JMP, 16'h0, 26'h0000100, 32'h0, 32'hB000_0104, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, BR_JMP, 16'h0, 26'h0000100, 32'h0, 32'hB000_0124, 1'b0, 1'b1, 1'b0);
        run(32'hB000_0128);
        cyc(1'b1, 1'b0, BR_REL, 16'h0, 26'h0, 32'h0, 32'hB000_0128, 1'b0, 1'b1, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
        cyc(1'b0, 1'b1, BR_JREG, 16'h0, 26'h0, 32'h0040_0002, 32'hB000_0128, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, BR_REL, 16'h0004, 26'h0, 32'h0, 32'hB000_0128, 1'b0, 1'b0, 1'b1);
        do_reset();
        run(32'hBFC0_0004);
`else
        // Low target bits are dropped on capture.
        cyc(1'b0, 1'b1, BR_JREG, 16'h0, 26'h0, 32'h0040_0002, 32'hB000_012C, 1'b1, 1'b1, 1'b0);
        run(32'h0040_0000);
        // Reset mid-slot discards the pending target.
        cyc(1'b0, 1'b1, BR_JREG, 16'h0, 26'h0, 32'h0000_1000, 32'h0040_0004, 1'b1, 1'b1, 1'b0);
        do_reset();
        run(32'hBFC0_0004);
`endif

        // Wrap-around through 0 with no halt from sequential flow.
        cyc(1'b0, 1'b1, BR_JREG, 16'h0, 26'h0, 32'hFFFF_FFF8, 32'hBFC0_0008, 1'b1, 1'b1, 1'b0);
        run(32'hFFFF_FFF8);
        run(32'hFFFF_FFFC);
        run(32'h0000_0000);
        run(32'h0000_0004);

        // Register jump to HALT_ADDR: slot, then halt; further requests ignored.
        cyc(1'b0, 1'b1, BR_JREG, 16'h0, 26'h0, 32'h0, 32'h0000_0008, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, BR_REL, 16'h0, 26'h0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, BR_REL, 16'h0005, 26'h0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, BR_JMP, 16'h0, 26'h0000123, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, BR_JREG, 16'h0, 26'h0, 32'h0000_0040, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
